// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: default parameter values and elaboration helpers shared by
// the FIFO pointer/status controller and its bus interface.
package fifo_ctrl_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 2;
  localparam int unsigned DEF_AF_LEVEL   = 3;
  localparam int unsigned DEF_AE_LEVEL   = 1;

  // Inclusive range test used for parameter sanity checks at elaboration.
  function automatic bit level_in_range(int unsigned lvl, int unsigned lo,
                                        int unsigned hi);
    return (lvl >= lo) && (lvl <= hi);
  endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// fifo_ctrl_if: request/status bundle between producer/consumer (master)
// and the FIFO controller (slave).
//   wr, rd, clr_err            : requests from producer/consumer
//   wr_en, w_addr, r_addr      : storage controls from the controller
//   full, empty, almost_*      : status decoded from the pointers
//   count                      : occupancy 0..DEPTH
//   overflow, underflow        : sticky error flags
interface fifo_ctrl_if
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                  wr;
  logic                  rd;
  logic                  clr_err;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr, rd, clr_err,
    input  wr_en, w_addr, r_addr, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr, rd, clr_err,
    output wr_en, w_addr, r_addr, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer and status controller for a circular FIFO on a
// register-file storage (sync write port, combinational read port).
//   clk    : clock, all state on rising edge
//   reset  : asynchronous, active-high
//   bus    : fifo_ctrl_if slave modport (requests in, storage controls and
//            status out). wr_en is combinational; addresses come straight
//            from the pointer registers; status flags and count are decoded
//            from registered pointers only; error flags are registered.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned AF_LEVEL   = DEF_AF_LEVEL,
  parameter int unsigned AE_LEVEL   = DEF_AE_LEVEL
) (
  input logic        clk,
  input logic        reset,
  fifo_ctrl_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned PTR_W = ADDR_WIDTH + 1;

  // Elaboration-time parameter checks.
  if (ADDR_WIDTH < 1) begin : g_aw_chk
    $error("fifo_ctrl: ADDR_WIDTH must be at least 1");
  end
  if (!level_in_range(AF_LEVEL, 1, DEPTH)) begin : g_af_chk
    $error("fifo_ctrl: AF_LEVEL out of range 1..DEPTH");
  end
  if (!level_in_range(AE_LEVEL, 0, DEPTH - 1)) begin : g_ae_chk
    $error("fifo_ctrl: AE_LEVEL out of range 0..DEPTH-1");
  end

  logic [PTR_W-1:0] w_ptr;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] count_c;
  logic             full_c;
  logic             empty_c;
  logic             do_wr_c;
  logic             do_rd_c;
  logic             overflow;
  logic             underflow;

  // Status decode from registered pointers; the extra MSB separates full
  // from empty when the address bits match.
  always_comb begin
    count_c = w_ptr - r_ptr;
    empty_c = (w_ptr == r_ptr);
    full_c  = (w_ptr[PTR_W-1] != r_ptr[PTR_W-1]) &&
              (w_ptr[PTR_W-2:0] == r_ptr[PTR_W-2:0]);
  end

  // Accepted requests. A push into a full FIFO is allowed when a pop frees
  // the head slot in the same cycle; a pop from empty is always rejected.
  always_comb begin
    do_wr_c = bus.wr & (~full_c | bus.rd);
    do_rd_c = bus.rd & ~empty_c;
  end

  // Pointer registers; wrap is the natural modulo of PTR_W bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr <= '0;
      r_ptr <= '0;
    end else begin
      if (do_wr_c) w_ptr <= w_ptr + PTR_W'(1);
      if (do_rd_c) r_ptr <= r_ptr + PTR_W'(1);
    end
  end

  // Sticky error flags; clearing wins over a same-cycle set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (bus.clr_err) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (bus.wr & full_c & ~bus.rd) overflow  <= 1'b1;
      if (bus.rd & empty_c)          underflow <= 1'b1;
    end
  end

  // Drive the bus.
  always_comb begin
    bus.wr_en        = do_wr_c;
    bus.w_addr       = w_ptr[ADDR_WIDTH-1:0];
    bus.r_addr       = r_ptr[ADDR_WIDTH-1:0];
    bus.full         = full_c;
    bus.empty        = empty_c;
    bus.count        = count_c;
    bus.almost_full  = (count_c >= PTR_W'(AF_LEVEL));
    bus.almost_empty = (count_c <= PTR_W'(AE_LEVEL));
    bus.overflow     = overflow;
    bus.underflow    = underflow;
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: self-checking bench for fifo_ctrl with a behavioural storage
// array and a queue-based reference model of FIFO contents and error flags.
module tb_fifo_ctrl;

  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AF    = 3;
  localparam int unsigned AE    = 1;

  logic clk;
  logic reset;
  logic [7:0] din;
  logic [7:0] mem [DEPTH];
  logic [7:0] rd_data;

  fifo_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  fifo_ctrl #(
    .ADDR_WIDTH(AW),
    .AF_LEVEL  (AF),
    .AE_LEVEL  (AE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file storage: sync write, combinational read.
  always_ff @(posedge clk) begin
    if (bus.wr_en) mem[bus.w_addr] <= din;
  end
  assign rd_data = mem[bus.r_addr];

  // Reference model state.
  logic [7:0] q[$];
  bit m_ovf, m_udf;
  int pushes, pops;
  int total, bad;

  typedef struct {
    bit   wr;
    bit   rd;
    bit   clr;
    logic [7:0] data;
    bit   e_wr_en;
    int   e_count;
    bit   e_full;
    bit   e_empty;
    bit   e_af;
    bit   e_ae;
    bit   e_ovf;
    bit   e_udf;
  } vec_t;

  vec_t tv[16];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    pushes = 0;
    pops   = 0;
  endtask

  task automatic check_status();
    int n;
    n = q.size();
    chk("count",        int'(bus.count),        n);
    chk("empty",        int'(bus.empty),        int'(n == 0));
    chk("full",         int'(bus.full),         int'(n == DEPTH));
    chk("almost_full",  int'(bus.almost_full),  int'(n >= AF));
    chk("almost_empty", int'(bus.almost_empty), int'(n <= AE));
    chk("overflow",     int'(bus.overflow),     int'(m_ovf));
    chk("underflow",    int'(bus.underflow),    int'(m_udf));
    chk("w_addr",       int'(bus.w_addr),       pushes % DEPTH);
    chk("r_addr",       int'(bus.r_addr),       pops % DEPTH);
  endtask

  // One clock of stimulus: drive, check combinational path, clock, update
  // the model, check registered/decoded state.
  task automatic step(input bit w, input bit r, input bit c,
                      input logic [7:0] d, output bit wen_seen);
    int n;
    bit mfull, mempty, acc_wr;
    bus.wr      = w;
    bus.rd      = r;
    bus.clr_err = c;
    din         = d;
    #1;
    n      = q.size();
    mfull  = (n == DEPTH);
    mempty = (n == 0);
    acc_wr = w && (!mfull || r);
    wen_seen = bus.wr_en;
    chk("wr_en", int'(bus.wr_en), int'(acc_wr));
    if (r && !mempty) chk("head_data", int'(rd_data), int'(q[0]));
    @(posedge clk);
    if (c) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (w && mfull && !r) m_ovf = 1'b1;
      if (r && mempty)      m_udf = 1'b1;
    end
    if (r && !mempty) begin
      void'(q.pop_front());
      pops++;
    end
    if (acc_wr) begin
      q.push_back(d);
      pushes++;
    end
    #1;
    check_status();
  endtask

  function automatic vec_t mk(bit w, bit r, bit c, logic [7:0] d, bit we,
                              int cnt, bit f, bit e, bit af, bit ae,
                              bit ov, bit ud);
    vec_t v;
    v.wr = w; v.rd = r; v.clr = c; v.data = d; v.e_wr_en = we;
    v.e_count = cnt; v.e_full = f; v.e_empty = e; v.e_af = af; v.e_ae = ae;
    v.e_ovf = ov; v.e_udf = ud;
    return v;
  endfunction

  initial begin
    bit wen;
    total = 0;
    bad   = 0;

    //         wr rd clr data   we cnt f e af ae ov ud
    tv[0]  = mk(1, 0, 0, 8'hA1, 1, 1, 0, 0, 0, 1, 0, 0);
    tv[1]  = mk(1, 0, 0, 8'hA2, 1, 2, 0, 0, 0, 0, 0, 0);
    tv[2]  = mk(1, 0, 0, 8'hA3, 1, 3, 0, 0, 1, 0, 0, 0);
    tv[3]  = mk(1, 0, 0, 8'hA4, 1, 4, 1, 0, 1, 0, 0, 0);
    tv[4]  = mk(1, 0, 0, 8'hA5, 0, 4, 1, 0, 1, 0, 1, 0);
    tv[5]  = mk(0, 0, 1, 8'h00, 0, 4, 1, 0, 1, 0, 0, 0);
    tv[6]  = mk(1, 1, 0, 8'hC9, 1, 4, 1, 0, 1, 0, 0, 0);
    tv[7]  = mk(0, 1, 0, 8'h00, 0, 3, 0, 0, 1, 0, 0, 0);
    tv[8]  = mk(0, 1, 0, 8'h00, 0, 2, 0, 0, 0, 0, 0, 0);
    tv[9]  = mk(0, 1, 0, 8'h00, 0, 1, 0, 0, 0, 1, 0, 0);
    tv[10] = mk(0, 1, 0, 8'h00, 0, 0, 0, 1, 0, 1, 0, 0);
    tv[11] = mk(0, 1, 0, 8'h00, 0, 0, 0, 1, 0, 1, 0, 1);
    tv[12] = mk(0, 0, 1, 8'h00, 0, 0, 0, 1, 0, 1, 0, 0);
    tv[13] = mk(1, 1, 0, 8'hB7, 1, 1, 0, 0, 0, 1, 0, 1);
    tv[14] = mk(0, 1, 0, 8'h00, 0, 0, 0, 1, 0, 1, 0, 1);
    tv[15] = mk(0, 1, 1, 8'h00, 0, 0, 0, 1, 0, 1, 0, 0);

    // Reset state; wr_en follows wr even while reset is held.
    reset       = 1'b1;
    bus.wr      = 1'b1;
    bus.rd      = 1'b0;
    bus.clr_err = 1'b0;
    din         = 8'h00;
    model_reset();
    #1;
    chk("reset_wr_en", int'(bus.wr_en), 1);
    bus.wr = 1'b0;
    @(posedge clk);
    #1;
    check_status();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 16; i++) begin
      step(tv[i].wr, tv[i].rd, tv[i].clr, tv[i].data, wen);
      chk($sformatf("tv%0d_wr_en", i), int'(wen), int'(tv[i].e_wr_en));
      chk($sformatf("tv%0d_count", i), int'(bus.count), tv[i].e_count);
      chk($sformatf("tv%0d_full", i), int'(bus.full), int'(tv[i].e_full));
      chk($sformatf("tv%0d_empty", i), int'(bus.empty), int'(tv[i].e_empty));
      chk($sformatf("tv%0d_af", i), int'(bus.almost_full), int'(tv[i].e_af));
      chk($sformatf("tv%0d_ae", i), int'(bus.almost_empty), int'(tv[i].e_ae));
      chk($sformatf("tv%0d_ovf", i), int'(bus.overflow), int'(tv[i].e_ovf));
      chk($sformatf("tv%0d_udf", i), int'(bus.underflow), int'(tv[i].e_udf));
    end

    // Continuous push/pop with two words in flight: count constant, wraps.
    step(1, 0, 0, 8'h10, wen);
    step(1, 0, 0, 8'h11, wen);
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0, 8'(8'h20 + i), wen);
      chk("stream_count", int'(bus.count), 2);
    end
    step(0, 1, 0, 8'h00, wen);
    step(0, 1, 0, 8'h00, wen);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 4, 8'($urandom), wen);
    end

    // Reset mid-stream: asynchronous return to empty.
    step(0, 0, 1, 8'h00, wen);
    while (q.size() > 0) step(0, 1, 0, 8'h00, wen);
    step(1, 0, 0, 8'hD1, wen);
    step(1, 0, 0, 8'hD2, wen);
    chk("pre_reset_count", int'(bus.count), 2);
    #2;
    reset = 1'b1;
    #1;
    chk("async_count", int'(bus.count), 0);
    chk("async_empty", int'(bus.empty), 1);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_status();
    step(1, 0, 0, 8'hE5, wen);
    chk("post_reset_r_addr", int'(bus.r_addr), 0);
    chk("post_reset_data", int'(rd_data), 8'hE5);
    step(0, 1, 0, 8'h00, wen);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
